// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the CPU load/store port.
// A request captured in IDLE waits LATENCY cycles in WAIT, then RESP issues a
// one-cycle ack with registered load data and a fault flag. Misaligned or
// out-of-range accesses fault: stores are suppressed and loads return zero.
// Optional feature macro: DMEM_BYTE_LANES_EN adds per-byte store enables (be).
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
`ifdef DMEM_BYTE_LANES_EN
  input  logic [3:0]  be,
`endif
  output logic        ack,
  output logic [31:0] rd,
  output logic        err,
  output logic        busy
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wd_r;
  logic        cur_we_s;
  logic [31:0] cur_addr_s;
  logic [31:0] cur_wd_s;
  logic [3:0]  cur_be_s;
  logic        fault_s;
  logic        enter_resp_s;
  logic [AW-1:0] idx_s;
  logic [31:0] mem [DEPTH];
`ifdef DMEM_BYTE_LANES_EN
  logic [3:0]  be_r;
`endif

  // Word access faults when not 4-byte aligned or beyond the last stored word.
  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  // Next-state logic for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_nx_s = (LATENCY == 0) ? RESP : WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd1) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Select the live request in IDLE (zero-latency path) or the captured one later.
  always_comb begin
    cur_we_s   = we_r;
    cur_addr_s = addr_r;
    cur_wd_s   = wd_r;
`ifdef DMEM_BYTE_LANES_EN
    cur_be_s   = be_r;
`else
    cur_be_s   = 4'hF;
`endif
    if (state_r == IDLE) begin
      cur_we_s   = we;
      cur_addr_s = addr;
      cur_wd_s   = wd;
`ifdef DMEM_BYTE_LANES_EN
      cur_be_s   = be;
`endif
    end else begin
      cur_we_s   = we_r;
    end
    fault_s      = addr_fault(cur_addr_s);
    idx_s        = cur_addr_s[2 +: AW];
    enter_resp_s = (state_nx_s == RESP) && (state_r != RESP);
  end

  // State register, wait counter and request capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wd_r    <= 32'd0;
`ifdef DMEM_BYTE_LANES_EN
      be_r    <= 4'd0;
`endif
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          if (req) begin
            cnt_r  <= LAT;
            we_r   <= we;
            addr_r <= addr;
            wd_r   <= wd;
`ifdef DMEM_BYTE_LANES_EN
            be_r   <= be;
`endif
          end
        end
        WAIT:    cnt_r <= cnt_r - 4'd1;
        RESP:    cnt_r <= cnt_r;
        default: cnt_r <= 4'd0;
      endcase
    end
  end

  // Registered response: ack/err only in the RESP cycle, rd holds between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack  <= 1'b0;
      err  <= 1'b0;
      rd   <= 32'd0;
      busy <= 1'b0;
    end else begin
      ack  <= enter_resp_s;
      err  <= enter_resp_s ? fault_s : 1'b0;
      busy <= (state_nx_s != IDLE);
      if (enter_resp_s && !cur_we_s) begin
        rd <= fault_s ? 32'd0 : mem[idx_s];
      end
    end
  end

  // Store commit on the edge entering RESP; faulting stores write nothing.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp_s && cur_we_s && !fault_s) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_be_s[k]) begin
          mem[idx_s][8*k +: 8] <= cur_wd_s[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the CPU load/store port; serves the datapath's memory requests (the memory side of the load/store interface).
- Multi-cycle req/ack handshake with a configurable wait-state count.
- Word-addressed storage with error signalling for misaligned or out-of-range accesses.
- Sits between the ALU address/rd2 store-data path and the mem2reg mux; lets the core run against slow memory.

Parameters:
- DEPTH, 64, number of 32-bit words stored (power of 2, 4..1024).
- LATENCY, 2, wait states between request capture and ack (0..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; captured with req.
- addr  in  32  byte address (ALU result); captured with req.
- wd  in  32  store data; captured with req.
- ack  out  1  one-cycle response strobe.
- rd  out  32  load data; valid while ack=1.
- err  out  1  access fault; valid while ack=1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset (rst=1 at a rising edge):
  - state=IDLE; ack=0, err=0, rd=0, busy=0; wait counter=0.
  - Memory contents are not cleared.
  - rst has priority over every other input.
- Reset mid-operation: the transaction is dropped, no ack is issued, and a store that has not reached RESP entry is not written.
- FSM states IDLE, WAIT, RESP; all outputs registered.
  - IDLE: when req=1, capture we/addr/wd and load cnt=LATENCY. Go to WAIT if LATENCY>0, else go directly to RESP.
  - WAIT: decrement cnt each cycle; when cnt==1, go to RESP.
  - RESP: ack=1 for exactly one cycle, then return to IDLE unconditionally.
  - req is ignored in WAIT and RESP. A req held high through RESP is accepted again in the first IDLE cycle.
- Timing: req sampled at edge N, so ack=1 during cycle N+1+LATENCY. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Address decode:
  - idx = addr[2 +: log2(DEPTH)].
  - Fault if addr[1:0]!=0 or addr[31:2]>=DEPTH.
- Store commit: the write to mem[idx] happens on the edge entering RESP. A faulting store writes nothing.
- Load data: registered on the edge entering RESP.
  - rd = mem[idx], reflecting any store committed earlier.
  - A faulting load returns rd=0.
- err equals the fault flag during the ack cycle. err=0 otherwise; rd holds its last value outside ack.
- busy=1 from the edge after req capture until the edge that returns the FSM to IDLE.

Optional Feature:
- Macro DMEM_BYTE_LANES_EN.
- Defined:
  - Adds input be[3:0], captured with req.
  - A store updates only byte lane k (bits 8k+7:8k) where be[k]=1; be=0000 on a store writes nothing and raises no error.
  - Loads ignore be and return the full word.
  - Alignment and range faults are unchanged.
- Undefined: the be port is absent and every store writes the full word.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> ack=0, err=0, rd=0, busy=0. With req=0 for 10 cycles, ack stays 0.
- Store/load, LATENCY=2:
  - req edge N, we=1, addr=0x08, wd=0xDEADBEEF -> ack only in cycle N+3, err=0.
  - Then a load at addr=0x08 -> rd=0xDEADBEEF with ack.
  - busy high for cycles N+1..N+3.
- Faults:
  - Load at addr=0x06 -> ack with err=1, rd=0.
  - Store at addr=0x100 (DEPTH=64) with wd=0x12345678 -> ack with err=1. mem[0] and mem[63] are unchanged on readback.
- Held req / back-to-back: req held high 12 cycles -> acks spaced exactly 4 cycles apart (LATENCY=2). req pulses during WAIT are ignored.
- Reset mid-op: store 0xAAAA5555 to 0x10 over an old value 0x11111111; assert rst during WAIT -> no ack; a later load of 0x10 returns 0x11111111.
- DMEM_BYTE_LANES_EN: mem[1]=0x00000000; store 0xA1B2C3D4 to 0x04 with be=0101 -> load returns 0x00B200D4.
